// File: rtl/deinterleaver_top_if.sv
// deinterleaver_top_if: bit-stream handshakes on both sides of the deinterleaver.
// The master modport belongs to the environment, and the slave modport belongs to the deinterleaver.
interface deinterleaver_top_if;
    logic data_in;
    logic valid_in;
    logic ready_out;
    logic data_out;
    logic valid_out;
    logic ready_in;
    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out
    );
    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out
    );
endinterface

// File: rtl/deinterleaver_top.sv
// deinterleaver_top: WiMAX 802.16 QPSK bit deinterleaver with ping-pong bit banks.
// Defining DEINT_FRAME_MARK_EN adds the last_out and blocks_out ports.
module deinterleaver_top #(
    parameter int NCBPS = 192,
    parameter int D     = 16
) (
    input logic clk,
    input logic resetN,
    deinterleaver_top_if.slave bus
`ifdef DEINT_FRAME_MARK_EN
    ,
    output logic        last_out,
    output logic [15:0] blocks_out
`endif
);
    localparam int R  = NCBPS / D;
    localparam int AW = $clog2(NCBPS);
    localparam int CW = $clog2(R);
    localparam int RW = $clog2(D);
    localparam logic [CW-1:0] COL_LAST = CW'(R - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(D - 1);
    localparam logic [8:0]    RD_LAST  = 9'(NCBPS - 1);

    logic [NCBPS-1:0] r_bank [2];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [AW-1:0]    r_wr_addr;
    logic [8:0]       r_rd_addr;

    logic w_ready;
    logic w_valid;
    logic w_wr_beat;
    logic w_wr_last;
    logic w_rd_beat;
    logic w_rd_last;

    assign w_ready   = !r_full[r_wr_bank];
    assign w_valid   = r_full[r_rd_bank];
    assign w_wr_beat = bus.valid_in && w_ready;
    assign w_wr_last = w_wr_beat && (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_rd_beat = w_valid && bus.ready_in;
    assign w_rd_last = w_rd_beat && (r_rd_addr == RD_LAST);

    assign bus.ready_out = w_ready;
    assign bus.valid_out = w_valid;
    assign bus.data_out  = r_bank[r_rd_bank][r_rd_addr[AW-1:0]];

    // k = D*col + row: step by D along a column, restart at the next row when col wraps
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_col     <= '0;
            r_row     <= '0;
            r_wr_addr <= '0;
        end else if (w_wr_beat) begin
            if (r_col == COL_LAST) begin
                r_col     <= '0;
                r_row     <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                r_wr_addr <= (r_row == ROW_LAST) ? '0 : AW'(r_row) + 1'b1;
            end else begin
                r_col     <= r_col + 1'b1;
                r_wr_addr <= r_wr_addr + AW'(D);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_beat)
            r_bank[r_wr_bank][r_wr_addr] <= bus.data_in;
    end

    // A bank being written is never full, so the two flag updates always hit different bits
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            if (w_wr_last) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_rd_beat)
                r_rd_addr <= w_rd_last ? '0 : r_rd_addr + 9'd1;
            if (w_rd_last) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

`ifdef DEINT_FRAME_MARK_EN
    logic [15:0] r_blocks;

    assign last_out   = w_valid && (r_rd_addr == RD_LAST);
    assign blocks_out = r_blocks;

    always_ff @(posedge clk) begin
        if (!resetN)
            r_blocks <= '0;
        else if (w_rd_last)
            r_blocks <= r_blocks + 16'd1;
    end
`endif
endmodule

// File: tb/tb_deinterleaver_top.sv
// tb_deinterleaver_top: directed and randomized-stall checks of deinterleaver_top
// against an independent (D*j) mod (NCBPS-1) address model.
module tb_deinterleaver_top;
    localparam int NCBPS = 192;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    deinterleaver_top_if bus ();
`ifdef DEINT_FRAME_MARK_EN
    logic        last_out;
    logic [15:0] blocks_out;
`endif

    deinterleaver_top dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
`ifdef DEINT_FRAME_MARK_EN
        ,
        .last_out(last_out),
        .blocks_out(blocks_out)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;
    bit src[$];
    bit exp_q[$];
    bit got[$];
    int acc, acc192_cyc, first_vo_cyc, gaps, stall_err, rdy_lows, blocks_read;

    function automatic int kmap(input int j);
        return (j == NCBPS - 1) ? j : (16 * j) % (NCBPS - 1);
    endfunction

    task automatic clear_q();
        src.delete();
        exp_q.delete();
        got.delete();
    endtask

    // onehot < 0 gives random data; otherwise only bit j = onehot is set
    task automatic add_block(input int onehot);
        bit b[NCBPS];
        bit o[NCBPS];
        for (int j = 0; j < NCBPS; j++) begin
            b[j] = (onehot < 0) ? 1'($urandom_range(1)) : (j == onehot);
            src.push_back(b[j]);
            o[kmap(j)] = b[j];
        end
        for (int k = 0; k < NCBPS; k++) exp_q.push_back(o[k]);
    endtask

    // Drives src with valid_in/ready_in at pin%/pout% and captures read beats into got
    task automatic run(input int pin, input int pout, input int max_cyc);
        bit pv = 1'b0, pr = 1'b0, pd = 1'b0;
        acc = 0; acc192_cyc = -1; first_vo_cyc = -1; gaps = 0; stall_err = 0; rdy_lows = 0;
        for (int c = 0; ; c++) begin
            @(posedge clk); #1;
            if (pv && !pr && (bus.valid_out !== 1'b1 || bus.data_out !== pd)) stall_err++;
            if (bus.valid_out === 1'b1 && first_vo_cyc < 0) first_vo_cyc = c;
            if (first_vo_cyc >= 0 && bus.valid_out !== 1'b1 && got.size() < exp_q.size()) gaps++;
            if (c >= max_cyc || (src.size() == 0 && got.size() >= exp_q.size())) break;
            if (src.size() > 0 && bus.ready_out !== 1'b1) rdy_lows++;
            bus.valid_in = (src.size() > 0) && ($urandom_range(99) < pin);
            bus.data_in  = (src.size() > 0) ? src[0] : 1'b0;
            bus.ready_in = $urandom_range(99) < pout;
            if (bus.valid_in && bus.ready_out === 1'b1) begin
                void'(src.pop_front());
                acc++;
                if (acc == NCBPS) acc192_cyc = c;
            end
            if (bus.valid_out === 1'b1 && bus.ready_in) begin
                got.push_back(bus.data_out);
                if (got.size() % NCBPS == 0) blocks_read++;
            end
            pv = bus.valid_out; pr = bus.ready_in; pd = bus.data_out;
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.valid_in = 1'b1; bus.data_in = 1'b1; bus.ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_out: got %b expected 0", bus.valid_out);
        end
        n_checks++;
        if (bus.ready_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_out: got %b expected 1", bus.ready_out);
        end
        bus.valid_in = 1'b0;
        resetN = 1'b1;
        blocks_read = 0;
    endtask

    task automatic test_onehot();
        int jt[4] = '{13, 12, 191, 1};
        int kt[4] = '{17, 1, 191, 16};
        for (int t = 0; t < 4; t++) begin
            int ones = 0;
            clear_q();
            add_block(jt[t]);
            run(100, 100, 1000);
            for (int i = 0; i < got.size(); i++) ones += int'(got[i]);
            n_checks++;
            if (got.size() !== NCBPS) begin
                n_fail++; $display("FAIL onehot_len j=%0d: got %0d expected %0d", jt[t], got.size(), NCBPS);
            end
            n_checks++;
            if ((got.size() > kt[t] ? got[kt[t]] : 1'b0) !== 1'b1) begin
                n_fail++; $display("FAIL onehot_bit j=%0d: out[%0d] got 0 expected 1", jt[t], kt[t]);
            end
            n_checks++;
            if (ones !== 1) begin
                n_fail++; $display("FAIL onehot_ones j=%0d: got %0d expected 1", jt[t], ones);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        clear_q();
        for (int b = 0; b < 4; b++) add_block(-1);
        run(100, 100, 2000);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL b2b_data: got %0d bad bits expected 0", bad);
        end
        n_checks++;
        if (first_vo_cyc !== acc192_cyc + 1) begin
            n_fail++; $display("FAIL b2b_latency: first valid cycle %0d expected %0d", first_vo_cyc, acc192_cyc + 1);
        end
        n_checks++;
        if (gaps !== 0) begin
            n_fail++; $display("FAIL b2b_out_gaps: got %0d expected 0", gaps);
        end
        n_checks++;
        if (rdy_lows !== 0) begin
            n_fail++; $display("FAIL b2b_in_gaps: got %0d expected 0", rdy_lows);
        end
`ifdef DEINT_FRAME_MARK_EN
        n_checks++;
        if (blocks_out !== 16'(blocks_read)) begin
            n_fail++; $display("FAIL blocks_out: got %0d expected %0d", blocks_out, blocks_read);
        end
`endif
    endtask

    task automatic test_backpressure();
        int bad = 0;
        clear_q();
        for (int b = 0; b < 3; b++) add_block(-1);
        run(100, 0, 400);
        n_checks++;
        if (acc !== 2 * NCBPS) begin
            n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", acc, 2 * NCBPS);
        end
        n_checks++;
        if (bus.ready_out !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_out: got %b expected 0", bus.ready_out);
        end
        run(100, 100, 2000);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL bp_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL bp_data: got %0d bad bits expected 0", bad);
        end
    endtask

    task automatic test_random_stall();
        int bad = 0;
        clear_q();
        for (int b = 0; b < 10; b++) add_block(-1);
        run(50, 50, 20000);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL stall_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL stall_data: got %0d bad bits expected 0", bad);
        end
        n_checks++;
        if (stall_err !== 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err);
        end
    endtask

    task automatic test_reset_mid_block();
        int bad = 0;
        clear_q();
        add_block(-1);
        add_block(-1);
        run(100, 0, NCBPS + 100);
        n_checks++;
        if (acc !== NCBPS + 100) begin
            n_fail++; $display("FAIL rst_pre_accepted: got %0d expected %0d", acc, NCBPS + 100);
        end
        n_checks++;
        if (bus.valid_out !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", bus.valid_out);
        end
        resetN = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        blocks_read = 0;
        n_checks++;
        if (bus.valid_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid_out: got %b expected 0", bus.valid_out);
        end
        n_checks++;
        if (bus.ready_out !== 1'b1) begin
            n_fail++; $display("FAIL rst_ready_out: got %b expected 1", bus.ready_out);
        end
        clear_q();
        add_block(-1);
        run(100, 100, 1000);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        n_checks++;
        if (got.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rst_post_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL rst_post_data: got %0d bad bits expected 0", bad);
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = 1'b0;
        bus.ready_in = 1'b0;
        test_reset();
        test_onehot();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
